mem_port_responder: RTL and testbench

Memory-side end of the 14-bit-address / 32-bit-data memory port. The upstream agent drives en/we/addr/data_i; this block owns the storage array, services writes, and returns read data after a fixed pipelined latency. It also provides post-reset clear sequencing, error flagging and access counters. It stands in for the packet memory behind any port-B style initiator, in RTL simulation and in formal harnesses.

---
 rtl/mem_port_pkg.sv | 13 +
 rtl/mem_rd_delay_line.sv | 41 ++++
 rtl/mem_port_responder.sv | 141 ++++++++++++++
 tb/tb_mem_port_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared constants and FSM state type for the memory-port responder.
package mem_port_pkg;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_resp_state_t;

endpackage

// File: rtl/mem_rd_delay_line.sv
// Delays stage-1 read valid/data by STAGES cycles; data advances only with valid,
// so the output word holds its last read value between pulses.
module mem_rd_delay_line #(
    parameter int STAGES = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [STAGES-1:0] vld;
    logic [DATA_W-1:0] dat [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= s1_valid;
            if (s1_valid) begin
                dat[0] <= s1_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign rd_valid = vld[STAGES-1];
    assign rd_data  = dat[STAGES-1];

endmodule

// File: rtl/mem_port_responder.sv
// Memory side of the port: owns the array, optional post-reset zero fill, pipelined reads
// (RD_LAT cycles), error pulse for dropped/out-of-range requests, wrapping access counters.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int ADDR_W         = mem_port_pkg::ADDR_W,
    parameter int DATA_W         = mem_port_pkg::DATA_W,
    parameter int DEPTH          = 2 ** ADDR_W,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("mem_port_responder: RD_LAT must be within 1..RD_LAT_MAX");
    end
    if (DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
        $error("mem_port_responder: DEPTH must be within 1..2**ADDR_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    mem_resp_state_t state, state_nxt;
    logic [IDX_W-1:0]  clr;
    logic [IDX_W-1:0]  idx;
    logic              rdy;
    logic              in_range;
    logic              rd_req;
    logic              acc_wr;
    logic              acc_rd;
    logic              err_nxt;
    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;

    assign idx      = addr[IDX_W-1:0];
    assign rdy      = (state == READY);
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    // Out-of-range reads still occupy a pipeline slot so the initiator always gets a response.
    assign rd_req   = rdy & en & ~we;
    assign acc_rd   = rd_req & in_range;
    assign acc_wr   = rdy & en & we & in_range;
    assign err_nxt  = en & (~rdy | ~in_range);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? INIT : READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (clr == IDX_W'(DEPTH - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr <= '0;
        end else if (state == INIT) begin
            clr <= clr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the INIT sweep zero-fills it instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr] <= '0;
        end else if (acc_wr) begin
            mem[idx] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            err    <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            s1_vld <= rd_req;
            if (rd_req) begin
                s1_dat <= in_range ? mem[idx] : '0;
            end
            err <= err_nxt;
            if (acc_wr) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (acc_rd) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_valid = s1_vld;
        assign data_o   = s1_dat;
    end else begin : g_latn
        mem_rd_delay_line #(
            .STAGES (RD_LAT - 1),
            .DATA_W (DATA_W)
        ) u_dly (
            .clk      (clk),
            .rst      (reset),
            .s1_valid (s1_vld),
            .s1_data  (s1_dat),
            .rd_valid (rd_valid),
            .rd_data  (data_o)
        );
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Drives three DEPTH=16 responders (RD_LAT 1, 3, 4) with identical requests and checks
// each against a shared memory model and a per-instance read-response scoreboard.
module tb_mem_port_responder;

    localparam int NI       = 3;
    localparam int LAT [NI] = '{1, 3, 4};

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        we;
    logic [13:0] addr;
    logic [31:0] data_i;

    logic [31:0] dout   [NI];
    logic        rv     [NI];
    logic        busy_w [NI];
    logic        err_w  [NI];
    logic [15:0] wc     [NI];
    logic [15:0] rc     [NI];

    int          cyc;
    int          n_cmp;
    int          n_err;
    exp_t        sb [$];
    logic [31:0] mem_m [16];
    logic        ready_m;
    logic [15:0] wr_m;
    logic [15:0] rd_m;

    mem_port_responder #(.DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) u_l1 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .data_i(data_i),
        .data_o(dout[0]), .rd_valid(rv[0]), .busy(busy_w[0]), .err(err_w[0]),
        .wr_cnt(wc[0]), .rd_cnt(rc[0]));

    mem_port_responder #(.DEPTH(16), .RD_LAT(3), .CLEAR_ON_RESET(1'b1)) u_l3 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .data_i(data_i),
        .data_o(dout[1]), .rd_valid(rv[1]), .busy(busy_w[1]), .err(err_w[1]),
        .wr_cnt(wc[1]), .rd_cnt(rc[1]));

    mem_port_responder #(.DEPTH(16), .RD_LAT(4), .CLEAR_ON_RESET(1'b1)) u_l4 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .data_i(data_i),
        .data_o(dout[2]), .rd_valid(rv[2]), .busy(busy_w[2]), .err(err_w[2]),
        .wr_cnt(wc[2]), .rd_cnt(rc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One cycle: pop/compare read responses on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rv[k] === 1'b1) begin
                int idx;
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].inst == k) idx = j;
                end
                n_cmp++;
                if (idx < 0) begin
                    n_err++;
                    $display("FAIL rd_valid_unexpected lat%0d cyc=%0d: got rd_valid=1 data_o=%h, required rd_valid=0",
                             LAT[k], cyc, dout[k]);
                end else begin
                    if (dout[k] !== sb[idx].dat || cyc != sb[idx].due) begin
                        n_err++;
                        $display("FAIL rd_data lat%0d: got data_o=%h at cyc %0d, required %h at cyc %0d",
                                 LAT[k], dout[k], cyc, sb[idx].dat, sb[idx].due);
                    end
                    sb.delete(idx);
                end
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due <= cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_valid_missing lat%0d: got no rd_valid by cyc %0d, required data %h at cyc %0d",
                         LAT[sb[j].inst], cyc, sb[j].dat, sb[j].due);
                sb.delete(j);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en     = 1'b0;
            we     = 1'($urandom);
            addr   = 14'($urandom);
            data_i = $urandom;
            tick();
        end
    endtask

    task automatic req(input logic w, input logic [13:0] a, input logic [31:0] d);
        logic        inr;
        logic        exp_err;
        logic [31:0] rdat;
        inr     = (a < 14'd16);
        exp_err = !ready_m || !inr;
        en      = 1'b1;
        we      = w;
        addr    = a;
        data_i  = d;
        if (ready_m && inr && w) begin
            mem_m[a[3:0]] = d;
            wr_m = wr_m + 16'd1;
        end
        if (ready_m && !w) begin
            rdat = inr ? mem_m[a[3:0]] : 32'h0;
            for (int k = 0; k < NI; k++) sb.push_back('{inst: k, due: cyc + LAT[k], dat: rdat});
            if (inr) rd_m = rd_m + 16'd1;
        end
        tick();
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (err_w[k] !== exp_err) begin
                n_err++;
                $display("FAIL err_pulse lat%0d we=%0d addr=%0d: got err=%b, required %b", LAT[k], w, a, err_w[k], exp_err);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        we    = 1'b0;
        sb.delete();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if ({dout[k], rv[k], err_w[k], wc[k], rc[k], busy_w[k]} !== {32'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_values lat%0d: got data_o=%h rd_valid=%b err=%b wr_cnt=%h rd_cnt=%h busy=%b, required 0/0/0/0/0/busy=1",
                         LAT[k], dout[k], rv[k], err_w[k], wc[k], rc[k], busy_w[k]);
            end
        end
        ready_m = 1'b0;
        wr_m    = '0;
        rd_m    = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 16; i++) tick();
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (busy_w[k] !== 1'b0) begin
                n_err++;
                $display("FAIL busy_after_clear lat%0d: got busy=%b, required 0", LAT[k], busy_w[k]);
            end
        end
        ready_m = 1'b1;
    endtask

    task automatic check_counters(input string tag);
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (wc[k] !== wr_m || rc[k] !== rd_m) begin
                n_err++;
                $display("FAIL counters_%s lat%0d: got wr_cnt=%h rd_cnt=%h, required %h %h", tag, LAT[k], wc[k], rc[k], wr_m, rd_m);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (busy_w[k] !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_during_clear lat%0d cycle %0d: got busy=%b, required 1", LAT[k], i, busy_w[k]);
                end
            end
            if (i == 4) begin
                en = 1'b0;
                for (int k = 0; k < NI; k++) begin
                    n_cmp++;
                    if (err_w[k] !== 1'b1) begin
                        n_err++;
                        $display("FAIL err_init_drop lat%0d: got err=%b, required 1", LAT[k], err_w[k]);
                    end
                end
            end
            if (i == 3) begin
                en   = 1'b1;
                we   = 1'b0;
                addr = 14'd5;
            end
            tick();
        end
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (busy_w[k] !== 1'b0) begin
                n_err++;
                $display("FAIL busy_falls lat%0d: got busy=%b, required 0 after 16 cycles", LAT[k], busy_w[k]);
            end
        end
        ready_m = 1'b1;
        check_counters("init_drop");
        req(1'b0, 14'd5, 32'h0);
        idle(5);
    endtask

    task automatic test_write_read();
        req(1'b1, 14'd10, 32'hDEADBEEF);
        req(1'b0, 14'd10, 32'h0);
        idle(6);
        check_counters("write_read");
    endtask

    task automatic test_back_to_back();
        req(1'b1, 14'd1, 32'h11);
        req(1'b1, 14'd2, 32'h22);
        req(1'b1, 14'd3, 32'h33);
        req(1'b0, 14'd1, 32'h0);
        req(1'b0, 14'd2, 32'h0);
        req(1'b0, 14'd3, 32'h0);
        idle(6);
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (dout[k] !== 32'h33 || rv[k] !== 1'b0) begin
                n_err++;
                $display("FAIL data_hold lat%0d: got data_o=%h rd_valid=%b, required 00000033 and 0", LAT[k], dout[k], rv[k]);
            end
        end
        check_counters("stream");
    endtask

    task automatic test_out_of_range();
        req(1'b1, 14'd20, 32'hAAAA);
        req(1'b0, 14'd20, 32'h0);
        idle(1);
        req(1'b1, 14'd16383, 32'h5555);
        req(1'b0, 14'd4, 32'h0);
        req(1'b0, 14'd3, 32'h0);
        idle(6);
        check_counters("out_of_range");
    endtask

    task automatic test_reset_mid_read();
        req(1'b0, 14'd1, 32'h0);
        idle(1);
        do_reset();
        wait_ready();
        req(1'b0, 14'd1, 32'h0);
        idle(6);
        check_counters("after_reset");
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 65535; i++) begin
            en     = 1'b1;
            we     = 1'b1;
            addr   = 14'd0;
            data_i = i;
            tick();
        end
        wr_m     = 16'hFFFF;
        mem_m[0] = 32'd65534;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (wc[k] !== 16'hFFFF) begin
                n_err++;
                $display("FAIL wr_cnt_ffff lat%0d: got %h, required ffff", LAT[k], wc[k]);
            end
        end
        data_i = 32'd65535;
        tick();
        wr_m     = 16'h0000;
        mem_m[0] = 32'd65535;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (wc[k] !== 16'h0000) begin
                n_err++;
                $display("FAIL wr_cnt_wrap lat%0d: got %h, required 0000", LAT[k], wc[k]);
            end
        end
        req(1'b0, 14'd0, 32'h0);
        idle(6);
        check_counters("wrap");
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        en      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_i  = '0;
        ready_m = 1'b0;
        wr_m    = '0;
        rd_m    = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        test_counter_wrap();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d outstanding reads, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
